axi_resp_backroute: RTL

AXI_RESP_BACKROUTE -- requirements
Module: axi_resp_backroute

---
 rtl/axi_node_pkg.sv | 20 ++
 rtl/axi_resp_slice.sv | 56 +++++
 rtl/axi_resp_backroute.sv | 107 ++++++++++
 3 files changed

// File: rtl/axi_node_pkg.sv
// Shared constants and helpers for the AXI node response-routing blocks.
package axi_node_pkg;

  localparam int DEF_N_TARG_PORT = 8;
  localparam int DEF_AXI_ID_IN   = 16;
  localparam int DEF_PAYLOAD_W   = 66;
  localparam int DEF_HAS_LAST    = 1;
  localparam int ERR_CNT_W       = 16;

  typedef enum logic {
    SLICE_EMPTY = 1'b0,
    SLICE_FULL  = 1'b1
  } slice_state_e;

  // Width needed to hold a target index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi_resp_slice.sv
// Single-entry output register (EMPTY/FULL) for one routed response beat.
module axi_resp_slice
  import axi_node_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         drain_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic [W-1:0] data_o
);

  slice_state_e state_q, state_d;
  logic [W-1:0] data_q, data_d;

  // A load while FULL only happens together with a drain, so it simply replaces the beat.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      SLICE_EMPTY: begin
        if (load_i) begin
          state_d = SLICE_FULL;
          data_d  = data_i;
        end
      end
      SLICE_FULL: begin
        if (load_i) begin
          data_d = data_i;
        end else if (drain_i) begin
          state_d = SLICE_EMPTY;
        end
      end
      default: state_d = SLICE_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLICE_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign full_o = (state_q == SLICE_FULL);
  assign data_o = data_q;

endmodule

// File: rtl/axi_resp_backroute.sv
// Routes a response beat back to the target port selected by the upper ID bits;
// unroutable beats are sunk and counted.
module axi_resp_backroute
  import axi_node_pkg::*;
#(
  parameter int N_TARG_PORT = DEF_N_TARG_PORT,
  parameter int AXI_ID_IN   = DEF_AXI_ID_IN,
  parameter int AXI_ID_OUT  = AXI_ID_IN + $clog2(N_TARG_PORT),
  parameter int PAYLOAD_W   = DEF_PAYLOAD_W,
  parameter int HAS_LAST    = DEF_HAS_LAST
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AXI_ID_OUT-1:0]  id_i,
  input  logic [PAYLOAD_W-1:0]   payload_i,
  input  logic                   last_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [AXI_ID_IN-1:0]   id_o,
  output logic [PAYLOAD_W-1:0]   payload_o,
  output logic                   last_o,
  output logic [N_TARG_PORT-1:0] valid_o,
  input  logic [N_TARG_PORT-1:0] ready_i,
  output logic                   decerr_o,
  output logic [ERR_CNT_W-1:0]   err_cnt_o
);

  localparam int IDX_W   = idx_width(N_TARG_PORT);
  localparam int ROUTE_W = AXI_ID_OUT - AXI_ID_IN;
  localparam int SLICE_W = IDX_W + AXI_ID_IN + 1 + PAYLOAD_W;

  logic [ROUTE_W-1:0]   route_idx;
  logic [31:0]          route_ext;
  logic                 routable;
  logic                 last_in;
  logic [SLICE_W-1:0]   slice_in;
  logic [SLICE_W-1:0]   slice_out;
  logic                 full;
  logic [IDX_W-1:0]     held_idx;
  logic                 held_ready;
  logic                 accept;
  logic                 load;
  logic                 drain;
  logic                 sink;
  logic                 decerr_q, decerr_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign route_idx = id_i[AXI_ID_OUT-1:AXI_ID_IN];
  assign route_ext = 32'(route_idx);
  assign routable  = (route_ext < 32'(N_TARG_PORT));
  assign last_in   = (HAS_LAST != 0) ? last_i : 1'b1;
  assign slice_in  = {route_ext[IDX_W-1:0], id_i[AXI_ID_IN-1:0], last_in, payload_i};

  assign {held_idx, id_o, last_o, payload_o} = slice_out;

  // Only the held target's ready matters; all other ready_i bits are ignored.
  always_comb begin
    held_ready = 1'b0;
    valid_o    = '0;
    for (int i = 0; i < N_TARG_PORT; i++) begin
      if (int'(held_idx) == i) begin
        held_ready = ready_i[i];
        valid_o[i] = full;
      end
    end
  end

  assign ready_o = !rst && (!full || held_ready);
  assign accept  = valid_i && ready_o;
  assign load    = accept && routable;
  assign sink    = accept && !routable;
  assign drain   = full && held_ready;

  axi_resp_slice #(
    .W (SLICE_W)
  ) u_slice (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .drain_i (drain),
    .data_i  (slice_in),
    .full_o  (full),
    .data_o  (slice_out)
  );

  always_comb begin
    decerr_d  = sink;
    err_cnt_d = err_cnt_q;
    if (sink && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      decerr_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      decerr_q  <= decerr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign decerr_o  = decerr_q;
  assign err_cnt_o = err_cnt_q;

endmodule
